// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the tick/step controller: controller state encoding
// and the default parameter widths used by the top and its divider.
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2
    } tick_state_e;

    localparam int DEFAULT_DIVIDER_BITS = 16;
    localparam int DEFAULT_BURST_BITS   = 8;
    localparam int DEFAULT_COUNT_BITS   = 32;

endpackage

// File: rtl/tick_divider.sv
// Reloadable down-counter. A load forces the count to load_value; while
// enabled the count decrements and reloads itself on reaching zero, so the
// zero flag repeats every load_value+1 enabled cycles.
module tick_divider
    import tick_ctrl_pkg::*;
#(
    parameter int Width = DEFAULT_DIVIDER_BITS
) (
    input  logic             GlobalClock,
    input  logic             ResetN,
    input  logic             load,
    input  logic             enable,
    input  logic [Width-1:0] load_value,
    output logic             is_zero
);

    logic [Width-1:0] cnt = '0;

    // Count register: explicit load wins, otherwise count down and wrap to load_value.
    always_ff @(posedge GlobalClock) begin
        // NOTE: registers use <= so every flop updates from pre-edge values, independent of statement order.
        if (!ResetN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (enable) begin
            if (cnt == '0) begin
                cnt <= load_value;
            end else begin
                cnt <= cnt - Width'(1);
            end
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/tick_step_controller.sv
// Tick/step controller: emits one-cycle ClockTick enables at a programmable
// period, either free-running (RUN) or for a fixed burst (BURST), and keeps
// a running total of emitted ticks.
module tick_step_controller
    import tick_ctrl_pkg::*;
#(
    parameter int DividerBits = DEFAULT_DIVIDER_BITS,
    parameter int BurstBits   = DEFAULT_BURST_BITS,
    parameter int CountBits   = DEFAULT_COUNT_BITS
) (
    input  logic                   GlobalClock,
    input  logic                   ResetN,
    input  logic [DividerBits-1:0] DivideValue,
    input  logic                   RunCmd,
    input  logic                   HaltCmd,
    input  logic                   StepCmd,
    input  logic [BurstBits-1:0]   BurstCount,
    output logic                   ClockTick,
    output logic                   Running,
    output logic                   BurstDone,
    output logic [CountBits-1:0]   TickCount
);

    tick_state_e          state = IDLE;
    tick_state_e          state_next;
    logic [BurstBits-1:0] remaining = '0;
    logic [BurstBits-1:0] remaining_next;
    logic [CountBits-1:0] tick_count = '0;
    logic                 burst_done = 1'b0;
    logic                 burst_done_next;
    logic                 cnt_load;
    logic                 cnt_zero;

    // The divider counts only while running; it is loaded when IDLE accepts a command.
    tick_divider #(
        .Width (DividerBits)
    ) u_divider (
        .GlobalClock (GlobalClock),
        .ResetN      (ResetN),
        .load        (cnt_load),
        .enable      (Running),
        .load_value  (DivideValue),
        .is_zero     (cnt_zero)
    );

    // Outputs decode from registers only, never from the command inputs.
    assign Running   = (state != IDLE);
    assign ClockTick = Running & cnt_zero;
    assign BurstDone = burst_done;
    assign TickCount = tick_count;

    // Next-state logic with command priority Halt > Step > Run.
    always_comb begin
        // NOTE: every signal written here is defaulted first, so no branch can leave one unassigned and infer a latch.
        state_next      = state;
        remaining_next  = remaining;
        burst_done_next = 1'b0;
        cnt_load        = 1'b0;

        unique case (state)
            IDLE: begin
                if (HaltCmd) begin
                    state_next = IDLE;
                end else if (StepCmd) begin
                    // A zero-length burst is accepted as a no-op.
                    if (BurstCount != '0) begin
                        state_next     = BURST;
                        remaining_next = BurstCount;
                        cnt_load       = 1'b1;
                    end
                end else if (RunCmd) begin
                    state_next = RUN;
                    cnt_load   = 1'b1;
                end
            end

            RUN: begin
                if (HaltCmd) begin
                    state_next = IDLE;
                end
            end

            BURST: begin
                if (ClockTick) begin
                    remaining_next = remaining - BurstBits'(1);
                end
                if (HaltCmd) begin
                    state_next = IDLE;
                end else if (RunCmd && !StepCmd) begin
                    // Switch to free-running without disturbing the current period.
                    state_next = RUN;
                end else if (ClockTick && (remaining == BurstBits'(1))) begin
                    state_next      = IDLE;
                    burst_done_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, burst length, completion pulse and tick total registers.
    always_ff @(posedge GlobalClock) begin
        if (!ResetN) begin
            state      <= IDLE;
            remaining  <= '0;
            burst_done <= 1'b0;
            tick_count <= '0;
        end else begin
            state      <= state_next;
            remaining  <= remaining_next;
            burst_done <= burst_done_next;
            if (ClockTick) begin
                tick_count <= tick_count + CountBits'(1);
            end
        end
    end

endmodule
